// File: rtl/kawari_clk_pkg.sv
// Shared clocking definitions for the dot4x timing front-end.
// Constants describe the PAL phi/dot relationship in dot4x ticks.
// No logic; imported by the phase generator and its users.
package kawari_clk_pkg;

    typedef enum logic [1:0] {
        S_WAIT_LOCK = 2'd0,
        S_STABLE    = 2'd1,
        S_RUN       = 2'd2
    } clk_state_t;

    // dot4x ticks per phi cycle, phase at which phi2 goes high, ticks per dot
    localparam int PHI_PERIOD     = 32;
    localparam int PHI_RISE_PHASE = 16;
    localparam int DOT_PERIOD     = 4;

    localparam int PHASE_W = $clog2(PHI_PERIOD);
    localparam int DOT_W   = $clog2(DOT_PERIOD);

endpackage

// File: rtl/sync_2ff.sv
// Two-flop level synchronizer for slow asynchronous inputs.
// Latency: 2 clocks from input change to output change.
// No backpressure; synchronous reset clears both stages.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // metastability stage followed by the stable output stage
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/dot4x_phase_gen.sv
// Lock qualification, reset release and phi/dot phase enables from clk_dot4x.
// Latency: release 2 + LOCK_WAIT + 1 clocks after locked rises; outputs registered.
// No backpressure; lock loss or reset forces rst_out and clears outputs next edge.
module dot4x_phase_gen
    import kawari_clk_pkg::*;
#(
    parameter int LOCK_WAIT  = 1024,
    parameter int LOCK_CNT_W = 16
) (
    input  logic               clk_dot4x,
    input  logic               reset,
    input  logic               locked,
    output logic               rst_out,
    output logic [PHASE_W-1:0] phase,
    output logic               clk_dot,
    output logic               dot_rising,
    output logic               clk_phi,
    output logic               phi_rising,
    output logic               phi_falling
);

    localparam logic [LOCK_CNT_W-1:0] CNT_LAST = LOCK_CNT_W'(LOCK_WAIT - 1);

    clk_state_t            r_st;
    logic [LOCK_CNT_W-1:0] r_lock_cnt;

    clk_state_t            w_st_nxt;
    logic [LOCK_CNT_W-1:0] w_cnt_nxt;
    logic                  w_locked_s;
    logic                  w_run_nxt;
    logic [PHASE_W-1:0]    w_phase_nxt;
    logic [DOT_W-1:0]      w_dot_pos;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .i_clk   (clk_dot4x),
        .i_reset (reset),
        .i_d     (locked),
        .o_q     (w_locked_s)
    );

    // next state: any loss of the synchronized lock returns to waiting
    always_comb begin
        w_st_nxt  = r_st;
        w_cnt_nxt = r_lock_cnt;
        unique case (r_st)
            S_WAIT_LOCK: begin
                if (w_locked_s) begin
                    w_st_nxt  = S_STABLE;
                    w_cnt_nxt = '0;
                end
            end
            S_STABLE: begin
                if (!w_locked_s) begin
                    w_st_nxt  = S_WAIT_LOCK;
                    w_cnt_nxt = '0;
                end else if (r_lock_cnt == CNT_LAST) begin
                    w_st_nxt  = S_RUN;
                end else begin
                    w_cnt_nxt = r_lock_cnt + 1'b1;
                end
            end
            S_RUN: begin
                if (!w_locked_s) begin
                    w_st_nxt  = S_WAIT_LOCK;
                    w_cnt_nxt = '0;
                end
            end
            default: begin
                w_st_nxt  = S_WAIT_LOCK;
                w_cnt_nxt = '0;
            end
        endcase
    end

    // phase starts at 0 on the entry edge and free-runs with natural 5-bit wrap
    always_comb begin
        w_run_nxt   = (w_st_nxt == S_RUN);
        w_phase_nxt = (w_run_nxt && (r_st == S_RUN)) ? r_phase_inc(phase) : '0;
        w_dot_pos   = w_phase_nxt[DOT_W-1:0];
    end

    function automatic logic [PHASE_W-1:0] r_phase_inc(input logic [PHASE_W-1:0] p);
        return p + PHASE_W'(1);
    endfunction

    // state, counter and all outputs registered from next-state values so
    // decodes line up with the phase they describe
    always_ff @(posedge clk_dot4x) begin
        if (reset) begin
            r_st        <= S_WAIT_LOCK;
            r_lock_cnt  <= '0;
            rst_out     <= 1'b1;
            phase       <= '0;
            clk_dot     <= 1'b0;
            dot_rising  <= 1'b0;
            clk_phi     <= 1'b0;
            phi_rising  <= 1'b0;
            phi_falling <= 1'b0;
        end else begin
            r_st        <= w_st_nxt;
            r_lock_cnt  <= w_cnt_nxt;
            rst_out     <= !w_run_nxt;
            phase       <= w_phase_nxt;
            clk_dot     <= w_run_nxt && (w_dot_pos < DOT_W'(DOT_PERIOD / 2));
            dot_rising  <= w_run_nxt && (w_dot_pos == '0);
            clk_phi     <= w_run_nxt && w_phase_nxt[PHASE_W-1];
            phi_rising  <= w_run_nxt && (w_phase_nxt == PHASE_W'(PHI_RISE_PHASE));
            phi_falling <= w_run_nxt && (w_phase_nxt == '0);
        end
    end

endmodule

// File: tb/tb_dot4x_phase_gen.sv
// Self-checking bench for dot4x_phase_gen against a lock-streak reference model.
module tb_dot4x_phase_gen;

    localparam int LW = 8;

    logic       clk_dot4x;
    logic       reset;
    logic       locked;
    logic       rst_out;
    logic [4:0] phase;
    logic       clk_dot;
    logic       dot_rising;
    logic       clk_phi;
    logic       phi_rising;
    logic       phi_falling;

    dot4x_phase_gen #(.LOCK_WAIT(LW), .LOCK_CNT_W(16)) dut (
        .clk_dot4x   (clk_dot4x),
        .reset       (reset),
        .locked      (locked),
        .rst_out     (rst_out),
        .phase       (phase),
        .clk_dot     (clk_dot),
        .dot_rising  (dot_rising),
        .clk_phi     (clk_phi),
        .phi_rising  (phi_rising),
        .phi_falling (phi_falling)
    );

    initial clk_dot4x = 1'b0;
    always #5 clk_dot4x = ~clk_dot4x;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // reference model: synchronizer pipeline plus a count of consecutive
    // edges at which the synchronized lock was high
    logic m_s1 = 1'b0;
    logic m_s2 = 1'b0;
    int   m_streak = 0;
    logic m_run;
    int   m_phase;

    int acc_dot, acc_phi_r, acc_phi_f, acc_phi_hi;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic tick(input logic rs, input logic lk);
        logic [4:0] exp_dec;
        reset  = rs;
        locked = lk;
        @(posedge clk_dot4x);
        cyc++;
        if (rs) begin
            m_s1 = 1'b0;
            m_s2 = 1'b0;
            m_streak = 0;
        end else begin
            m_streak = m_s2 ? m_streak + 1 : 0;
            m_s2 = m_s1;
            m_s1 = lk;
        end
        m_run   = (m_streak >= LW + 1);
        m_phase = m_run ? ((m_streak - (LW + 1)) % 32) : 0;
        @(negedge clk_dot4x);
        exp_dec = {m_run && ((m_phase % 4) < 2),
                   m_run && ((m_phase % 4) == 0),
                   m_run && (m_phase >= 16),
                   m_run && (m_phase == 16),
                   m_run && (m_phase == 0)};
        check("rst_out", 32'(rst_out), 32'(!m_run));
        check("phase", 32'(phase), 32'(m_phase));
        check("decode", 32'({clk_dot, dot_rising, clk_phi, phi_rising, phi_falling}), 32'(exp_dec));
        acc_dot    += int'(dot_rising);
        acc_phi_r  += int'(phi_rising);
        acc_phi_f  += int'(phi_falling);
        acc_phi_hi += int'(clk_phi);
    endtask

    // hold locked high and confirm the first rst_out=0 edge lands on exp_edge
    task automatic await_release(input string tag, input int exp_edge);
        int rel = -1;
        for (int i = 0; i < 100; i++) begin
            tick(1'b0, 1'b1);
            if (rst_out === 1'b0) begin
                rel = cyc;
                break;
            end
        end
        check(tag, 32'(rel), 32'(exp_edge));
    endtask

    task automatic run_until_phase(input int target);
        for (int i = 0; i < 80; i++) begin
            if (m_run && m_phase == target) break;
            tick(1'b0, 1'b1);
        end
        check("reach_phase", 32'(m_run && m_phase == target), 32'd1);
    endtask

    initial begin
        int c0;
        reset  = 1'b1;
        locked = 1'b0;

        // reset pulse then 100 cycles unlocked
        tick(1'b1, 1'b0);
        for (int i = 0; i < 100; i++) tick(1'b0, 1'b0);

        // first release, then 320 cycles of running
        c0 = cyc + 1;
        await_release("release1", c0 + 2 + LW);
        acc_dot    = int'(dot_rising);
        acc_phi_r  = int'(phi_rising);
        acc_phi_f  = int'(phi_falling);
        acc_phi_hi = int'(clk_phi);
        for (int i = 0; i < 319; i++) tick(1'b0, 1'b1);
        check("dot_rising_cnt", 32'(acc_dot), 32'd80);
        check("phi_rising_cnt", 32'(acc_phi_r), 32'd10);
        check("phi_falling_cnt", 32'(acc_phi_f), 32'd10);
        check("clk_phi_high", 32'(acc_phi_hi), 32'd160);

        // lock loss at phase 20, then restore
        run_until_phase(20);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0);
        check("lost_rst", 32'(rst_out), 32'd1);
        c0 = cyc + 1;
        await_release("release2", c0 + 2 + LW);

        // one-cycle glitch while qualifying at lock_cnt=5
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0);
        for (int i = 0; i < 40 && m_streak != 6; i++) tick(1'b0, 1'b1);
        check("reach_cnt5", 32'(m_streak), 32'd6);
        tick(1'b0, 1'b0);
        c0 = cyc + 1;
        await_release("release_glitch", c0 + 2 + LW);

        // reset at phase 31 with lock held
        run_until_phase(31);
        tick(1'b1, 1'b1);
        check("reset_rst", 32'(rst_out), 32'd1);
        c0 = cyc + 1;
        await_release("release_reset", c0 + 2 + LW);

        // randomized lock segments with occasional reset pulses
        for (int seg = 0; seg < 60; seg++) begin
            logic lk;
            int   len;
            lk  = ($urandom_range(0, 3) != 0);
            len = lk ? int'($urandom_range(5, 60)) : int'($urandom_range(1, 4));
            for (int i = 0; i < len; i++)
                tick(($urandom_range(0, 199) == 0), lk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dot4x_phase_gen.md
Name: dot4x_phase_gen

Overview:
- Sits directly downstream of the 17.734475 MHz PAL MMCM clock generator.
- Consumes that generator's clk_dot4x output and its LOCKED output.
- Qualifies lock and produces the design-wide synchronous reset release.
- Derives the dot-clock and phi phase enables, plus a phase index, that all VIC-II timing logic runs from (32 dot4x ticks per phi cycle, 8 dots per phi).

Parameters:
- LOCK_WAIT, 1024: consecutive synchronized-locked cycles required before reset release. Legal range 2..65535.
- LOCK_CNT_W, 16: width of the lock-stability counter. Must satisfy 2^LOCK_CNT_W > LOCK_WAIT.

Ports:
- clk_dot4x, input, 1: sole clock (~31.5 MHz PAL dot4x).
- reset, input, 1: synchronous, active-high.
- locked, input, 1: MMCM LOCKED, asynchronous to clk_dot4x.
- rst_out, output, 1: synchronous active-high reset for downstream timing logic.
- phase, output, 5: position within the phi cycle, 0..31.
- clk_dot, output, 1: dot-clock level.
- dot_rising, output, 1: one-cycle enable at each dot-clock start.
- clk_phi, output, 1: phi2 level.
- phi_rising, output, 1: one-cycle pulse when phi goes high.
- phi_falling, output, 1: one-cycle pulse at phi-cycle start.

Behaviour:
- Interface rules (decided): one clock, clk_dot4x. Reset is synchronous and active-high on port reset. No other clock or async reset.
- Lock synchronizer:
  - locked passes through a 2-flop synchronizer to give locked_s. Both flops reset to 0.
  - Latency from locked to locked_s is 2 cycles.
- State machine (st), reset state S_WAIT_LOCK, lock_cnt=0:
  - S_WAIT_LOCK: if locked_s, go to S_STABLE with lock_cnt=0.
  - S_STABLE: if !locked_s, go to S_WAIT_LOCK with lock_cnt=0. Else lock_cnt++. When lock_cnt==LOCK_WAIT-1 while locked_s, go to S_RUN.
  - S_RUN: if !locked_s, go to S_WAIT_LOCK on that edge. Else stay.
- rst_out:
  - Registered, = (next st != S_RUN).
  - It falls on the same edge st enters S_RUN and rises on the same edge st leaves S_RUN.
  - Reset value 1.
- phase:
  - Held 0 whenever next st != S_RUN.
  - On the entry edge into S_RUN, phase=0. So the first cycle with rst_out=0 has phase=0.
  - In S_RUN, phase increments by 1 per clock and wraps 31→0. The 5-bit natural wrap is required.
- Decoded outputs are all registered, computed from the next phase so they are coincident with the phase they describe:
  - clk_dot = (phase[1:0]==0 or 1).
  - dot_rising = (phase[1:0]==0).
  - clk_phi = phase[4].
  - phi_rising = (phase==16).
  - phi_falling = (phase==0).
- While rst_out=1, all five decoded outputs and phase are 0. The phase==0 decode is suppressed.
- The first phi_falling and dot_rising pulse occurs in the first rst_out=0 cycle.
- Per 32-cycle period in S_RUN: dot_rising pulses 8 times, phi_rising once, phi_falling once.
- Lock loss mid-operation: when locked_s drops, rst_out=1 and all outputs clear on the next edge. No partial phi cycle completes.
- reset mid-operation: same as lock loss. In addition, both synchronizer flops clear, and a full re-qualification (2 + LOCK_WAIT cycles minimum) follows.
- Simultaneous reset and locked_s rising: reset wins.
- A locked glitch shorter than one synchronized sample during S_STABLE restarts lock_cnt from 0.

Decomposition:
- Package kawari_clk_pkg contains:
  - state enum {S_WAIT_LOCK, S_STABLE, S_RUN}.
  - PHI_PERIOD=32.
  - PHI_RISE_PHASE=16.
  - DOT_PERIOD=4.
- One sub-module, sync_2ff: generic 2-flop level synchronizer with synchronous active-high reset. It is reused by other async-input paths.

Test Plan (bench uses LOCK_WAIT=8):
- Reset pulse, locked=0 for 100 cycles → rst_out=1 and phase=0 throughout. All decoded outputs 0.
- locked rises at cycle T → rst_out falls at edge T+2+8 (±1 per synchronizer alignment, checked exactly against the model). That cycle has phase=0, phi_falling=1, dot_rising=1, clk_dot=1, clk_phi=0.
- Run 320 cycles after release → phase follows 0..31 ten times. dot_rising count=80, phi_rising count=10 (each at phase 16), clk_phi high exactly 16 of every 32 cycles.
- Drop locked at phase 20 → two cycles later rst_out=1 and phase=0 with all outputs 0. Restoring locked gives a re-release exactly 2+8 cycles later, again starting at phase 0.
- In S_STABLE at lock_cnt=5, deassert locked for 1 cycle → lock_cnt restarts. Release is delayed a full 8 cycles after locked_s returns.
- Assert reset for 1 cycle while in S_RUN at phase 31 with locked=1 → next cycle rst_out=1 and phase=0. Re-release occurs 2+8 cycles after reset deasserts.
